mem_init_loader: RTL and testbench
==================================

Name: mem_init_loader

Overview:
- Upstream boot/debug loader for the 5-stage pipelined core.
- Consumes a 32-bit valid/ready word stream (host or UART bridge) and writes instruction and data memory through the core's debug init ports.
- Holds the core in init mode (enable_debug=1) while loading, then releases it.
- Each memory entry is a word pair (data1, data2) at an 8-byte-aligned byte address. This matches the doubleword debug write path.

Parameters:
- DM_ADDRESS, 9, byte-address width of both memories' debug ports.
- DATA_W, 32, stream word width and memory data width.
- CNT_W, 9, width of header pair-count field and of entry_count.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts word this cycle
- load_req  in  1  one-cycle request to re-enter loading from RUN
- enable_debug  out  1  core hold/init enable, to datapath
- debug_addr  out  DM_ADDRESS  data-memory debug address
- debug_data1  out  DATA_W  data-memory debug word 1
- debug_data2  out  DATA_W  data-memory debug word 2
- debug_inst_addr  out  DM_ADDRESS  instruction-memory debug address
- debug_inst_data1  out  DATA_W  instruction-memory word 1
- debug_inst_data2  out  DATA_W  instruction-memory word 2
- dm_we  out  1  one-cycle strobe: new data-memory entry presented
- im_we  out  1  one-cycle strobe: new instruction-memory entry presented
- core_start  out  1  one-cycle pulse when core is released
- entry_count  out  CNT_W+1  entries written since last HDR entry from reset/load_req; saturates at all-ones
- align_err  out  1  sticky misaligned-start flag

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. Reset state is HDR.
  - enable_debug=1, in_ready=1.
  - All addr/data outputs 0; dm_we=im_we=core_start=0; entry_count=0; align_err=0.
- Handshake: a word transfers on posedge when in_valid&&in_ready. in_valid/in_data ignored otherwise.
- Header word fields:
  - [31] END: release core.
  - [30] TGT: 0=instruction, 1=data.
  - [24:16] start byte address.
  - [8:0] pair count N.
  - Other bits ignored.
- States: HDR, W1, W2, WR, RUN. in_ready=1 in HDR/W1/W2, 0 in WR/RUN.
- HDR, header accepted:
  - END=1: go to RUN. enable_debug drops to 0 the next cycle; core_start pulses that same cycle. END overrides N.
  - END=0, N=0: stay in HDR.
  - Otherwise latch TGT, N, and start address with [2:0] forced to 0. If [18:16]!=0, set align_err. Go to W1.
- W1: accept word, latch as data1, go to W2.
- W2: accept word, latch as data2, go to WR.
- WR (one cycle): load the selected target's addr/data output registers; they are visible the cycle after WR.
  - Pulse im_we or dm_we in that same visible cycle.
  - Increment entry_count; address += 8, mod 2^DM_ADDRESS (0x1F8 wraps to 0x000); N -= 1.
  - If N becomes 0, go to HDR; else go to W1.
- Per-entry throughput: 3 cycles minimum with in_valid held high.
- Non-selected target outputs hold their previous values. The memories write continuously while enable_debug=1, so held values rewrite idempotently.
- Address/data outputs hold their last values in RUN.
- Before the first entry of a target, its port presents addr 0 / data 0. Entry 0 is therefore cleared unless it is loaded.
- RUN: enable_debug=0, in_ready=0.
  - load_req=1: go to HDR, enable_debug=1 next cycle, entry_count cleared. align_err is not cleared (only reset clears it).
  - load_req outside RUN is ignored.
- Stalls: in_valid low in W1/W2/HDR waits indefinitely; no timeout.
- Reset mid-load returns to HDR with all reset values. Partially written memory contents are not undone.

Test Plan:
- Reset, header 0x00000002 (inst, addr 0, N=2), words A0,A1,B0,B1 back-to-back:
  - im_we pulses twice, 3 cycles apart.
  - debug_inst_addr 0x000 then 0x008; data pairs (A0,A1), (B0,B1).
  - dm_we never pulses; entry_count=2.
- Header 0x40100001 (data, addr 0x010, N=1), words 0x11111111, 0x22222222:
  - dm_we pulse, debug_addr=0x010, data1/data2 as sent.
  - Inst outputs unchanged.
- Header 0x80000000:
  - in_ready falls; enable_debug=0 and core_start=1 for exactly one cycle, the cycle after acceptance.
  - Further in_valid ignored.
- Header 0x41F80002 (data, 0x1F8, N=2): entries at 0x1F8 then 0x000 (wrap).
- Header 0x00030001:
  - align_err=1, entry written at 0x000.
  - After END and load_req, align_err remains 1 and entry_count=0.
- in_valid toggling 1/0 between payload words: same writes as the no-gap case, one write per complete pair. Assert reset during W2: all outputs at reset values the next cycle, state HDR.

Source files
------------

// File: rtl/mem_init_loader_if.sv
// mem_init_loader_if: valid/ready word stream feeding the memory init loader
interface mem_init_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mem_init_loader.sv
// mem_init_loader: stream-driven boot loader writing core instruction/data memories through debug init ports
module mem_init_loader #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_init_loader_if.slave      s,
    input  logic                  load_req,
    output logic                  enable_debug,
    output logic [DM_ADDRESS-1:0] debug_addr,
    output logic [DATA_W-1:0]     debug_data1,
    output logic [DATA_W-1:0]     debug_data2,
    output logic [DM_ADDRESS-1:0] debug_inst_addr,
    output logic [DATA_W-1:0]     debug_inst_data1,
    output logic [DATA_W-1:0]     debug_inst_data2,
    output logic                  dm_we,
    output logic                  im_we,
    output logic                  core_start,
    output logic [CNT_W:0]        entry_count,
    output logic                  align_err
);
    typedef enum logic [2:0] {HDR, W1, W2, WR, RUN} state_t;

    state_t                state, state_nxt;
    logic                  xfer;
    logic                  tgt;
    logic [CNT_W-1:0]      cnt;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     d1, d2;
    logic                  hdr_end;
    logic [CNT_W-1:0]      hdr_n;
    logic                  unused_hdr;

    assign xfer       = s.in_valid && s.in_ready;
    assign hdr_end    = s.in_data[31];
    assign hdr_n      = s.in_data[CNT_W-1:0];
    assign unused_hdr = ^{s.in_data[29:16+DM_ADDRESS], s.in_data[15:CNT_W]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= HDR;
        else       state <= state_nxt;
    end

    // Next-state and handshake/hold outputs; the core is held in init mode everywhere except RUN
    always_comb begin
        state_nxt    = state;
        s.in_ready   = (state == HDR) || (state == W1) || (state == W2);
        enable_debug = (state != RUN);
        case (state)
            HDR:     if (xfer) state_nxt = hdr_end ? RUN : (hdr_n == '0 ? HDR : W1);
            W1:      if (xfer) state_nxt = W2;
            W2:      if (xfer) state_nxt = WR;
            WR:      state_nxt = (cnt == CNT_W'(1)) ? HDR : W1;
            RUN:     if (load_req) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    // Header latch, payload capture and per-target output registers with one-cycle write strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt              <= 1'b0;
            cnt              <= '0;
            addr             <= '0;
            d1               <= '0;
            d2               <= '0;
            debug_addr       <= '0;
            debug_data1      <= '0;
            debug_data2      <= '0;
            debug_inst_addr  <= '0;
            debug_inst_data1 <= '0;
            debug_inst_data2 <= '0;
            dm_we            <= 1'b0;
            im_we            <= 1'b0;
            core_start       <= 1'b0;
            entry_count      <= '0;
            align_err        <= 1'b0;
        end else begin
            dm_we      <= 1'b0;
            im_we      <= 1'b0;
            core_start <= 1'b0;
            case (state)
                HDR: if (xfer) begin
                    if (hdr_end) core_start <= 1'b1;
                    else if (hdr_n != '0) begin
                        tgt  <= s.in_data[30];
                        cnt  <= hdr_n;
                        addr <= {s.in_data[19 +: DM_ADDRESS-3], 3'b000};
                        if (s.in_data[18:16] != 3'b000) align_err <= 1'b1;
                    end
                end
                W1: if (xfer) d1 <= s.in_data;
                W2: if (xfer) d2 <= s.in_data;
                WR: begin
                    if (tgt) begin
                        debug_addr  <= addr;
                        debug_data1 <= d1;
                        debug_data2 <= d2;
                        dm_we       <= 1'b1;
                    end else begin
                        debug_inst_addr  <= addr;
                        debug_inst_data1 <= d1;
                        debug_inst_data2 <= d2;
                        im_we            <= 1'b1;
                    end
                    entry_count <= (&entry_count) ? entry_count : entry_count + (CNT_W+1)'(1);
                    addr        <= addr + DM_ADDRESS'(8);
                    cnt         <= cnt - CNT_W'(1);
                end
                RUN: if (load_req) entry_count <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_init_loader.sv
// tb_mem_init_loader: directed self-checking bench for mem_init_loader
module tb_mem_init_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic        enable_debug, dm_we, im_we, core_start, align_err;
    logic [8:0]  debug_addr, debug_inst_addr;
    logic [31:0] debug_data1, debug_data2, debug_inst_data1, debug_inst_data2;
    logic [9:0]  entry_count;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    typedef struct {
        int          c;
        logic [8:0]  a;
        logic [31:0] d1;
        logic [31:0] d2;
    } ev_t;
    ev_t im_q[$];
    ev_t dm_q[$];

    mem_init_loader_if #(.DATA_W(32)) bus ();

    mem_init_loader dut (
        .clk(clk), .reset(reset), .s(bus), .load_req(load_req),
        .enable_debug(enable_debug),
        .debug_addr(debug_addr), .debug_data1(debug_data1), .debug_data2(debug_data2),
        .debug_inst_addr(debug_inst_addr), .debug_inst_data1(debug_inst_data1),
        .debug_inst_data2(debug_inst_data2),
        .dm_we(dm_we), .im_we(im_we), .core_start(core_start),
        .entry_count(entry_count), .align_err(align_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle a write strobe is seen, with the port contents of that cycle
    always @(negedge clk) begin
        ev_t e;
        e.c = cyc;
        if (im_we) begin
            e.a = debug_inst_addr; e.d1 = debug_inst_data1; e.d2 = debug_inst_data2;
            im_q.push_back(e);
        end
        if (dm_we) begin
            e.a = debug_addr; e.d1 = debug_data1; e.d2 = debug_data2;
            dm_q.push_back(e);
        end
    end

    // Present a word at a negedge and hold it until one posedge with in_ready high has passed
    task automatic push(input logic [31:0] w);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            checks++; errors++;
            $display("FAIL push_timeout word %h never accepted", w);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (enable_debug !== 1'b1) begin errors++; $display("FAIL rst_enable_debug got %b exp 1", enable_debug); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
        checks++; if ({debug_addr, debug_inst_addr} !== 18'h0) begin errors++; $display("FAIL rst_addrs got %h/%h exp 0", debug_addr, debug_inst_addr); end
        checks++; if ({debug_data1, debug_data2, debug_inst_data1, debug_inst_data2} !== 128'h0) begin errors++; $display("FAIL rst_data got nonzero exp 0"); end
        checks++; if ({dm_we, im_we, core_start, align_err} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {dm_we, im_we, core_start, align_err}); end
        checks++; if (entry_count !== 10'd0) begin errors++; $display("FAIL rst_entry_count got %0d exp 0", entry_count); end
    endtask

    task automatic test_inst_load();
        im_q.delete(); dm_q.delete();
        push(32'h0000_0002);
        push(32'hA0A0_A0A0); push(32'hA1A1_A1A1);
        push(32'hB0B0_B0B0); push(32'hB1B1_B1B1);
        settle();
        checks++; if (im_q.size() !== 2) begin errors++; $display("FAIL inst_we_count got %0d exp 2", im_q.size()); end
        if (im_q.size() == 2) begin
            checks++; if (im_q[0].a !== 9'h000 || im_q[0].d1 !== 32'hA0A0_A0A0 || im_q[0].d2 !== 32'hA1A1_A1A1) begin errors++; $display("FAIL inst_entry0 got %h %h %h exp 000 a0a0a0a0 a1a1a1a1", im_q[0].a, im_q[0].d1, im_q[0].d2); end
            checks++; if (im_q[1].a !== 9'h008 || im_q[1].d1 !== 32'hB0B0_B0B0 || im_q[1].d2 !== 32'hB1B1_B1B1) begin errors++; $display("FAIL inst_entry1 got %h %h %h exp 008 b0b0b0b0 b1b1b1b1", im_q[1].a, im_q[1].d1, im_q[1].d2); end
            checks++; if (im_q[1].c - im_q[0].c !== 3) begin errors++; $display("FAIL inst_spacing got %0d exp 3", im_q[1].c - im_q[0].c); end
        end
        checks++; if (dm_q.size() !== 0) begin errors++; $display("FAIL inst_no_dm got %0d exp 0", dm_q.size()); end
        checks++; if (entry_count !== 10'd2) begin errors++; $display("FAIL inst_entry_count got %0d exp 2", entry_count); end
    endtask

    task automatic test_data_load();
        im_q.delete(); dm_q.delete();
        push(32'h4010_0001);
        push(32'h1111_1111); push(32'h2222_2222);
        settle();
        checks++; if (dm_q.size() !== 1) begin errors++; $display("FAIL data_we_count got %0d exp 1", dm_q.size()); end
        if (dm_q.size() == 1) begin
            checks++; if (dm_q[0].a !== 9'h010 || dm_q[0].d1 !== 32'h1111_1111 || dm_q[0].d2 !== 32'h2222_2222) begin errors++; $display("FAIL data_entry got %h %h %h exp 010 11111111 22222222", dm_q[0].a, dm_q[0].d1, dm_q[0].d2); end
        end
        checks++; if (im_q.size() !== 0) begin errors++; $display("FAIL data_no_im got %0d exp 0", im_q.size()); end
        checks++; if (debug_inst_addr !== 9'h008 || debug_inst_data1 !== 32'hB0B0_B0B0 || debug_inst_data2 !== 32'hB1B1_B1B1) begin errors++; $display("FAIL data_inst_hold got %h %h %h exp 008 b0b0b0b0 b1b1b1b1", debug_inst_addr, debug_inst_data1, debug_inst_data2); end
        checks++; if (entry_count !== 10'd3) begin errors++; $display("FAIL data_entry_count got %0d exp 3", entry_count); end
    endtask

    task automatic test_wrap();
        dm_q.delete();
        push(32'h41F8_0002);
        push(32'hC0C0_C0C0); push(32'hC1C1_C1C1);
        push(32'hD0D0_D0D0); push(32'hD1D1_D1D1);
        settle();
        checks++; if (dm_q.size() !== 2) begin errors++; $display("FAIL wrap_we_count got %0d exp 2", dm_q.size()); end
        if (dm_q.size() == 2) begin
            checks++; if (dm_q[0].a !== 9'h1F8 || dm_q[0].d1 !== 32'hC0C0_C0C0) begin errors++; $display("FAIL wrap_entry0 got %h %h exp 1f8 c0c0c0c0", dm_q[0].a, dm_q[0].d1); end
            checks++; if (dm_q[1].a !== 9'h000 || dm_q[1].d2 !== 32'hD1D1_D1D1) begin errors++; $display("FAIL wrap_entry1 got %h %h exp 000 d1d1d1d1", dm_q[1].a, dm_q[1].d2); end
        end
        checks++; if (entry_count !== 10'd5) begin errors++; $display("FAIL wrap_entry_count got %0d exp 5", entry_count); end
    endtask

    task automatic test_gaps();
        logic [31:0] w [5];
        w[0] = 32'h0000_0002; w[1] = 32'hE0E0_E0E0; w[2] = 32'hE1E1_E1E1;
        w[3] = 32'h6060_6060; w[4] = 32'h6161_6161;
        im_q.delete(); dm_q.delete();
        for (int i = 0; i < 5; i++) begin
            push(w[i]);
            bus.in_valid = 1'b0;
            bus.in_data  = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        settle();
        checks++; if (im_q.size() !== 2 || dm_q.size() !== 0) begin errors++; $display("FAIL gap_we_count got %0d/%0d exp 2/0", im_q.size(), dm_q.size()); end
        if (im_q.size() == 2) begin
            checks++; if (im_q[0].a !== 9'h000 || im_q[0].d1 !== 32'hE0E0_E0E0 || im_q[0].d2 !== 32'hE1E1_E1E1) begin errors++; $display("FAIL gap_entry0 got %h %h %h exp 000 e0e0e0e0 e1e1e1e1", im_q[0].a, im_q[0].d1, im_q[0].d2); end
            checks++; if (im_q[1].a !== 9'h008 || im_q[1].d1 !== 32'h6060_6060 || im_q[1].d2 !== 32'h6161_6161) begin errors++; $display("FAIL gap_entry1 got %h %h %h exp 008 60606060 61616161", im_q[1].a, im_q[1].d1, im_q[1].d2); end
        end
        checks++; if (entry_count !== 10'd7) begin errors++; $display("FAIL gap_entry_count got %0d exp 7", entry_count); end
    endtask

    task automatic test_align();
        im_q.delete();
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_pre got %b exp 0", align_err); end
        push(32'h0003_0001);
        push(32'hF0F0_F0F0); push(32'hF1F1_F1F1);
        settle();
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_flag got %b exp 1", align_err); end
        checks++; if (im_q.size() !== 1) begin errors++; $display("FAIL align_we_count got %0d exp 1", im_q.size()); end
        if (im_q.size() == 1) begin
            checks++; if (im_q[0].a !== 9'h000 || im_q[0].d1 !== 32'hF0F0_F0F0) begin errors++; $display("FAIL align_entry got %h %h exp 000 f0f0f0f0", im_q[0].a, im_q[0].d1); end
        end
        checks++; if (entry_count !== 10'd8) begin errors++; $display("FAIL align_entry_count got %0d exp 8", entry_count); end
    endtask

    task automatic test_end();
        im_q.delete(); dm_q.delete();
        push(32'h8000_0000);
        bus.in_data = 32'h0000_0002;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL end_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (enable_debug !== 1'b0 || core_start !== 1'b1) begin errors++; $display("FAIL end_release got en=%b start=%b exp en=0 start=1", enable_debug, core_start); end
        @(negedge clk);
        checks++; if (enable_debug !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL end_pulse got en=%b start=%b exp en=0 start=0", enable_debug, core_start); end
        repeat (6) @(negedge clk);
        checks++; if (im_q.size() !== 0 || dm_q.size() !== 0 || bus.in_ready !== 1'b0 || entry_count !== 10'd8) begin errors++; $display("FAIL run_ignore got im=%0d dm=%0d rdy=%b cnt=%0d exp 0 0 0 8", im_q.size(), dm_q.size(), bus.in_ready, entry_count); end
        bus.in_valid = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        checks++; if (enable_debug !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL reload_state got en=%b rdy=%b exp 1 1", enable_debug, bus.in_ready); end
        checks++; if (entry_count !== 10'd0 || align_err !== 1'b1) begin errors++; $display("FAIL reload_regs got cnt=%0d aerr=%b exp 0 1", entry_count, align_err); end
    endtask

    task automatic test_reset_mid();
        im_q.delete(); dm_q.delete();
        push(32'h0008_0001);
        push(32'h7777_7777);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (enable_debug !== 1'b1 || bus.in_ready !== 1'b1 || align_err !== 1'b0 || entry_count !== 10'd0) begin errors++; $display("FAIL mid_rst_ctrl got en=%b rdy=%b aerr=%b cnt=%0d exp 1 1 0 0", enable_debug, bus.in_ready, align_err, entry_count); end
        checks++; if (debug_inst_addr !== 9'h0 || debug_inst_data1 !== 32'h0 || debug_addr !== 9'h0 || debug_data2 !== 32'h0) begin errors++; $display("FAIL mid_rst_outputs got %h %h %h %h exp 0", debug_inst_addr, debug_inst_data1, debug_addr, debug_data2); end
        reset = 1'b0;
        push(32'h4020_0001);
        push(32'h3333_3333); push(32'h4444_4444);
        settle();
        checks++; if (im_q.size() !== 0 || dm_q.size() !== 1) begin errors++; $display("FAIL mid_after got im=%0d dm=%0d exp 0 1", im_q.size(), dm_q.size()); end
        if (dm_q.size() == 1) begin
            checks++; if (dm_q[0].a !== 9'h020 || dm_q[0].d1 !== 32'h3333_3333 || dm_q[0].d2 !== 32'h4444_4444) begin errors++; $display("FAIL mid_entry got %h %h %h exp 020 33333333 44444444", dm_q[0].a, dm_q[0].d1, dm_q[0].d2); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_inst_load();
        test_data_load();
        test_wrap();
        test_gaps();
        test_align();
        test_end();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
